// File: rtl/free_list.sv
// Physical register free list for the rename stage: circular buffer
// with speculative head, committed head and tail pointers.
//
// Ports:
//   clk, resetn    - clock, asynchronous active-low reset
//   alloc_req      - per-lane request for a destination preg
//   alloc_ready    - a full-width allocation can be granted this cycle
//   alloc_id       - granted preg per lane (compacted, lane order)
//   commit_num     - allocations retired this cycle
//   release_valid  - per-lane return of a stale preg
//   release_id     - returned preg ids
//   flush          - rewind speculative head to committed head
//   free_count     - free pregs in the speculative view
module free_list #(
    parameter int PREG_NUM      = 128,
    parameter int ARCH_REGS     = 32,
    parameter int ALLOC_WIDTH   = 2,
    parameter int RELEASE_WIDTH = 2,
    localparam int PREG_W       = $clog2(PREG_NUM),
    localparam int CNT_W        = $clog2(ALLOC_WIDTH) + 1
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic [ALLOC_WIDTH-1:0]                  alloc_req,
    output logic                                    alloc_ready,
    output logic [ALLOC_WIDTH-1:0][PREG_W-1:0]      alloc_id,
    input  logic [CNT_W-1:0]                        commit_num,
    input  logic [RELEASE_WIDTH-1:0]                release_valid,
    input  logic [RELEASE_WIDTH-1:0][PREG_W-1:0]    release_id,
    input  logic                                    flush,
    output logic [PREG_W:0]                         free_count
);

    typedef logic [PREG_W:0] ptr_t;

    localparam int   FREE_INIT = PREG_NUM - ARCH_REGS;
    localparam ptr_t TAIL_INIT = ptr_t'(FREE_INIT);
    localparam ptr_t MAX_FREE  = ptr_t'(FREE_INIT);
    localparam ptr_t ALLOC_W_P = ptr_t'(ALLOC_WIDTH);

    logic [PREG_W-1:0] entry_q [PREG_NUM];
    logic [PREG_W-1:0] entry_d [PREG_NUM];

    ptr_t spec_head_q, spec_head_d;
    ptr_t cmt_head_q, cmt_head_d;
    ptr_t tail_q, tail_d;

    ptr_t alloc_off;
    ptr_t rel_off;
    ptr_t rd_ptr;
    ptr_t wr_ptr;
    ptr_t free_next;
    logic fire;

    // Read side: lane i takes the entry after all lower requesting lanes,
    // so grants stay packed regardless of which lanes ask.
    always_comb begin
        free_count  = tail_q - spec_head_q;
        alloc_ready = (free_count >= ALLOC_W_P) && !flush;
        alloc_off   = '0;
        rd_ptr      = '0;
        alloc_id    = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            rd_ptr      = spec_head_q + alloc_off;
            alloc_id[i] = entry_q[rd_ptr[PREG_W-1:0]];
            alloc_off   = alloc_off + ptr_t'(alloc_req[i]);
        end
        fire = alloc_ready && (|alloc_req);
    end

    // Write side: released ids are appended at the tail, packed.
    always_comb begin
        entry_d = entry_q;
        rel_off = '0;
        wr_ptr  = '0;
        for (int i = 0; i < RELEASE_WIDTH; i++) begin
            if (release_valid[i]) begin
                wr_ptr = tail_q + rel_off;
                entry_d[wr_ptr[PREG_W-1:0]] = release_id[i];
                rel_off = rel_off + ptr_t'(1);
            end
        end
    end

    // Pointer updates; flush rewinds to the committed head including
    // any commits retiring in the same cycle.
    always_comb begin
        cmt_head_d  = cmt_head_q + ptr_t'(commit_num);
        tail_d      = tail_q + rel_off;
        spec_head_d = spec_head_q;
        if (flush) begin
            spec_head_d = cmt_head_d;
        end else if (fire) begin
            spec_head_d = spec_head_q + alloc_off;
        end
        free_next = tail_d - spec_head_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < PREG_NUM; i++) begin
                entry_q[i] <= (i < FREE_INIT) ? PREG_W'(ARCH_REGS + i) : '0;
            end
            spec_head_q <= '0;
            cmt_head_q  <= '0;
            tail_q      <= TAIL_INIT;
        end else begin
            entry_q     <= entry_d;
            spec_head_q <= spec_head_d;
            cmt_head_q  <= cmt_head_d;
            tail_q      <= tail_d;
        end
    end

    // Releasing more pregs than exist outside the architectural set
    // means a preg was freed twice.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!resetn)
        (|release_valid) |-> (free_next <= MAX_FREE)
    );

endmodule

// File: tb/tb_free_list.sv
// Directed testbench for free_list.
// Each task drives one scenario and checks inline.
module tb_free_list;

    logic            clk;
    logic            resetn;
    logic [1:0]      alloc_req;
    logic            alloc_ready;
    logic [1:0][6:0] alloc_id;
    logic [1:0]      commit_num;
    logic [1:0]      release_valid;
    logic [1:0][6:0] release_id;
    logic            flush;
    logic [7:0]      free_count;

    int n_pass;
    int n_total;

    free_list dut (
        .clk           (clk),
        .resetn        (resetn),
        .alloc_req     (alloc_req),
        .alloc_ready   (alloc_ready),
        .alloc_id      (alloc_id),
        .commit_num    (commit_num),
        .release_valid (release_valid),
        .release_id    (release_id),
        .flush         (flush),
        .free_count    (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        alloc_req     = '0;
        commit_num    = '0;
        release_valid = '0;
        release_id    = '0;
        flush         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        alloc_req = 2'b01;
        #1;
        n_total++;
        if (free_count !== 8'd96)
            $display("FAIL reset_free got %0d want 96", free_count);
        else n_pass++;
        n_total++;
        if (alloc_ready !== 1'b1)
            $display("FAIL reset_ready got %b want 1", alloc_ready);
        else n_pass++;
        n_total++;
        if (alloc_id[0] !== 7'd32)
            $display("FAIL reset_id0 got %0d want 32", alloc_id[0]);
        else n_pass++;
        alloc_req = '0;
    endtask

    task automatic test_alloc_pair();
        do_reset();
        alloc_req = 2'b11;
        #1;
        n_total++;
        if (alloc_id[0] !== 7'd32 || alloc_id[1] !== 7'd33)
            $display("FAIL pair_ids got {%0d,%0d} want {33,32}",
                     alloc_id[1], alloc_id[0]);
        else n_pass++;
        tick();
        alloc_req = '0;
        #1;
        n_total++;
        if (free_count !== 8'd94)
            $display("FAIL pair_free got %0d want 94", free_count);
        else n_pass++;
    endtask

    task automatic test_compaction();
        do_reset();
        alloc_req = 2'b10;
        #1;
        n_total++;
        if (alloc_id[1] !== 7'd32)
            $display("FAIL comp_lane1 got %0d want 32", alloc_id[1]);
        else n_pass++;
        tick();
        alloc_req = 2'b01;
        #1;
        n_total++;
        if (alloc_id[0] !== 7'd33)
            $display("FAIL comp_lane0 got %0d want 33", alloc_id[0]);
        else n_pass++;
        tick();
        alloc_req = '0;
        #1;
        n_total++;
        if (free_count !== 8'd94)
            $display("FAIL comp_free got %0d want 94", free_count);
        else n_pass++;
    endtask

    task automatic test_exhaust();
        do_reset();
        alloc_req = 2'b11;
        repeat (48) tick();
        alloc_req = '0;
        #1;
        n_total++;
        if (free_count !== 8'd0 || alloc_ready !== 1'b0)
            $display("FAIL empty got free=%0d rdy=%b want 0,0",
                     free_count, alloc_ready);
        else n_pass++;
        alloc_req = 2'b11;
        tick();
        alloc_req = '0;
        #1;
        n_total++;
        if (free_count !== 8'd0)
            $display("FAIL empty_hold got %0d want 0", free_count);
        else n_pass++;
        release_valid = 2'b11;
        release_id[0] = 7'd5;
        release_id[1] = 7'd7;
        #1;
        n_total++;
        if (alloc_ready !== 1'b0)
            $display("FAIL no_bypass got rdy=%b want 0", alloc_ready);
        else n_pass++;
        tick();
        release_valid = '0;
        #1;
        n_total++;
        if (free_count !== 8'd2 || alloc_ready !== 1'b1)
            $display("FAIL refill got free=%0d rdy=%b want 2,1",
                     free_count, alloc_ready);
        else n_pass++;
        alloc_req = 2'b11;
        #1;
        n_total++;
        if (alloc_id[0] !== 7'd5 || alloc_id[1] !== 7'd7)
            $display("FAIL refill_ids got {%0d,%0d} want {7,5}",
                     alloc_id[1], alloc_id[0]);
        else n_pass++;
        tick();
        alloc_req = '0;
        #1;
        n_total++;
        if (free_count !== 8'd0)
            $display("FAIL refill_free got %0d want 0", free_count);
        else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        alloc_req = 2'b11;
        tick();
        tick();
        alloc_req = '0;
        #1;
        n_total++;
        if (free_count !== 8'd92)
            $display("FAIL fl_pre got %0d want 92", free_count);
        else n_pass++;
        flush      = 1'b1;
        commit_num = 2'd2;
        alloc_req  = 2'b11;
        #1;
        n_total++;
        if (alloc_ready !== 1'b0)
            $display("FAIL fl_ready got %b want 0", alloc_ready);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (free_count !== 8'd94)
            $display("FAIL fl_free got %0d want 94", free_count);
        else n_pass++;
        alloc_req = 2'b11;
        #1;
        n_total++;
        if (alloc_id[0] !== 7'd34 || alloc_id[1] !== 7'd35)
            $display("FAIL fl_ids got {%0d,%0d} want {35,34}",
                     alloc_id[1], alloc_id[0]);
        else n_pass++;
        tick();
        alloc_req = '0;
        flush     = 1'b1;
        tick();
        idle();
        #1;
        n_total++;
        if (free_count !== 8'd94)
            $display("FAIL fl2_free got %0d want 94", free_count);
        else n_pass++;
        alloc_req = 2'b01;
        #1;
        n_total++;
        if (alloc_id[0] !== 7'd34)
            $display("FAIL fl2_id got %0d want 34", alloc_id[0]);
        else n_pass++;
        alloc_req = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        alloc_req = 2'b11;
        repeat (43) tick();
        alloc_req = '0;
        #1;
        n_total++;
        if (free_count !== 8'd10)
            $display("FAIL b2b_pre got %0d want 10", free_count);
        else n_pass++;
        alloc_req        = 2'b11;
        release_valid    = 2'b01;
        release_id[0]    = 7'd3;
        commit_num       = 2'd2;
        #1;
        n_total++;
        if (alloc_id[0] !== 7'd118 || alloc_id[1] !== 7'd119)
            $display("FAIL b2b_ids got {%0d,%0d} want {119,118}",
                     alloc_id[1], alloc_id[0]);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (free_count !== 8'd9)
            $display("FAIL b2b_free got %0d want 9", free_count);
        else n_pass++;
        alloc_req = 2'b11;
        repeat (4) tick();
        alloc_req = 2'b01;
        #1;
        n_total++;
        if (free_count !== 8'd1 || alloc_ready !== 1'b0)
            $display("FAIL b2b_tail got free=%0d rdy=%b want 1,0",
                     free_count, alloc_ready);
        else n_pass++;
        n_total++;
        if (alloc_id[0] !== 7'd3)
            $display("FAIL b2b_rel_id got %0d want 3", alloc_id[0]);
        else n_pass++;
        alloc_req = '0;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        alloc_req = 2'b11;
        repeat (10) tick();
        alloc_req = 2'b01;
        #1;
        n_total++;
        if (free_count !== 8'd76)
            $display("FAIL mid_pre got %0d want 76", free_count);
        else n_pass++;
        resetn = 1'b0;
        #1;
        n_total++;
        if (free_count !== 8'd96 || alloc_id[0] !== 7'd32)
            $display("FAIL mid_rst got free=%0d id0=%0d want 96,32",
                     free_count, alloc_id[0]);
        else n_pass++;
        tick();
        resetn = 1'b1;
        alloc_req = '0;
        #1;
        n_total++;
        if (free_count !== 8'd96 || alloc_ready !== 1'b1)
            $display("FAIL mid_post got free=%0d rdy=%b want 96,1",
                     free_count, alloc_ready);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        resetn  = 1'b0;
        idle();
        test_reset();
        test_alloc_pair();
        test_compaction();
        test_exhaust();
        test_flush();
        test_back_to_back();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
